// File: rtl/uart_frame_decoder_pkg.sv
// Shared constants, state encodings and checksum helper
// for the UART command-frame decoder.
package uart_frame_decoder_pkg;

    localparam logic [7:0] CAC_FRAME_SOF = 8'hA5;
    localparam logic [7:0] CAC_FRAME_ACK = 8'h06;
    localparam logic [7:0] CAC_FRAME_NAK = 8'h15;

    localparam int DEF_TIMEOUT_CYCLES = 100000;

    typedef enum logic [3:0] {
        S_SOF,
        S_CMD,
        S_DH,
        S_DL,
        S_CHK,
        S_EXEC,
        S_RDWAIT,
        S_RESP_H,
        S_RESP_L,
        S_RESP_CHK,
        S_ACK,
        S_NAK
    } state_t;

    // Writes cover CMD, DH and DL; reads cover CMD alone.
    function automatic logic [7:0] frame_chk(
        input logic [7:0] cmd,
        input logic [7:0] dh,
        input logic [7:0] dl
    );
        return cmd[7] ? (cmd ^ dh ^ dl) : cmd;
    endfunction

endpackage

// File: rtl/uart_frame_decoder_timeout.sv
// Inter-byte idle counter: single-cycle expired pulse after
// TIMEOUT_CYCLES enabled cycles without a clear.
module frame_timeout_counter
    import uart_frame_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expired = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Framed register-access command decoder between the UART
// RX/TX FIFOs and a simple register bus.
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter int BITLEN         = 8,
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITLEN-1:0] rx_data,
    input  logic              rx_empty,
    output logic              rx_read,
    output logic [BITLEN-1:0] tx_data,
    output logic              tx_write,
    input  logic              tx_full,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              err_chk,
    output logic              err_timeout,
    output logic [7:0]        err_count
);

    state_t state_q, state_d;

    logic              pending_q;
    logic [BITLEN-1:0] cmd_q, dh_q, dl_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rx_state, in_frame, byte_vld, chk_ok, tmo_exp;

    assign rx_state = state_q inside {S_SOF, S_CMD, S_DH, S_DL, S_CHK};
    assign in_frame = state_q inside {S_CMD, S_DH, S_DL, S_CHK};
    assign byte_vld = pending_q;
    assign chk_ok   = (state_q == S_CHK) && byte_vld &&
                      (rx_data == frame_chk(cmd_q, dh_q, dl_q));

    // A pending fetch blocks the next pop, giving one fetch per 2 cycles.
    assign rx_read = !rst && rx_state && !rx_empty && !pending_q;

    frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .en     (in_frame),
        .clr    (byte_vld),
        .expired(tmo_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_SOF;
            pending_q <= 1'b0;
            cmd_q     <= '0;
            dh_q      <= '0;
            dl_q      <= '0;
            rdata_q   <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= rx_read;
            if (byte_vld && state_q == S_CMD) cmd_q <= rx_data;
            if (byte_vld && state_q == S_DH)  dh_q  <= rx_data;
            if (byte_vld && state_q == S_DL)  dl_q  <= rx_data;
            // Bus address/data only change once a frame is proven good.
            if (chk_ok) begin
                reg_addr <= cmd_q[ADDR_W-1:0];
                if (cmd_q[7]) reg_wdata <= {dh_q, dl_q};
            end
            if (state_q == S_RDWAIT) rdata_q <= reg_rdata;
            if ((err_chk || err_timeout) && err_count != 8'hFF)
                err_count <= err_count + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_data     = '0;
        tx_write    = 1'b0;
        reg_we      = 1'b0;
        reg_re      = 1'b0;
        err_chk     = 1'b0;
        err_timeout = 1'b0;
        unique case (state_q)
            S_SOF: begin
                if (byte_vld && rx_data == CAC_FRAME_SOF) state_d = S_CMD;
            end
            S_CMD: begin
                if (byte_vld) state_d = rx_data[7] ? S_DH : S_CHK;
            end
            S_DH: begin
                if (byte_vld) state_d = S_DL;
            end
            S_DL: begin
                if (byte_vld) state_d = S_CHK;
            end
            S_CHK: begin
                if (byte_vld) state_d = chk_ok ? S_EXEC : S_NAK;
            end
            S_EXEC: begin
                reg_we  = cmd_q[7];
                reg_re  = !cmd_q[7];
                state_d = cmd_q[7] ? S_ACK : S_RDWAIT;
            end
            S_RDWAIT: begin
                state_d = S_RESP_H;
            end
            S_RESP_H: begin
                tx_data  = rdata_q[DATA_W-1:BITLEN];
                tx_write = !tx_full;
                if (!tx_full) state_d = S_RESP_L;
            end
            S_RESP_L: begin
                tx_data  = rdata_q[BITLEN-1:0];
                tx_write = !tx_full;
                if (!tx_full) state_d = S_RESP_CHK;
            end
            S_RESP_CHK: begin
                tx_data  = rdata_q[DATA_W-1:BITLEN] ^ rdata_q[BITLEN-1:0];
                tx_write = !tx_full;
                if (!tx_full) state_d = S_SOF;
            end
            S_ACK: begin
                tx_data  = CAC_FRAME_ACK;
                tx_write = !tx_full;
                if (!tx_full) state_d = S_SOF;
            end
            S_NAK: begin
                tx_data  = CAC_FRAME_NAK;
                tx_write = !tx_full;
                err_chk  = !tx_full;
                if (!tx_full) state_d = S_SOF;
            end
            default: state_d = S_SOF;
        endcase
        // Only asserted in frame states while no byte is being sampled.
        if (tmo_exp) begin
            err_timeout = 1'b1;
            state_d     = S_SOF;
        end
    end

endmodule
